// File: rtl/serial_subtractor8_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Master drives the request side; slave returns the registered result.
interface serial_subtractor8_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  d, bout, ovf, zero, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output d, bout, ovf, zero, busy, done
    );
endinterface

// File: rtl/serial_subtractor8.sv
// Bit-serial two's-complement subtractor: A - B - bin, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor8_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic             w_ai;
    logic             w_bi;
    logic             w_diff;
    logic             w_brw_n;
    logic [WIDTH-1:0] w_sh_n;
    logic             w_last;

    assign w_ai    = r_a[0];
    assign w_bi    = r_b[0];
    assign w_diff  = w_ai ^ w_bi ^ r_brw;
    assign w_brw_n = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_brw);
    assign w_sh_n  = {w_diff, r_sh[WIDTH-1:1]};
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_brw   <= bus.bin;
                        r_cnt   <= '0;
                        r_sh    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_brw <= w_brw_n;
                    r_sh  <= w_sh_n;
                    r_cnt <= r_cnt + CW'(1);
                    // MSB step: borrow in vs out of the top cell gives overflow
                    if (w_last) begin
                        r_d     <= w_sh_n;
                        r_bout  <= w_brw_n;
                        r_ovf   <= r_brw ^ w_brw_n;
                        r_zero  <= (w_sh_n == '0);
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
